// File: rtl/data_mem_resp.sv
// Data-memory responder for the MEM stage of the 5-stage pipeline.
// A word-addressed RAM sits behind an IDLE/BUSY/RESP handshake with a
// configurable number of wait states. The request is latched on acceptance,
// so the datapath may change its outputs while the access is in flight.
module data_mem_resp #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  output logic        mem_stall,
  output logic        mem_ack,
  output logic        mem_err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  // The counter only ever holds WAIT_CYCLES-1 down to 0.
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    wr_q, wr_d;
  logic                    ill_q, ill_d;
  logic [31:0]             din_q, din_d;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;

  logic                    req_s;
  logic                    illegal_s;
  logic [ADDR_WIDTH-1:0]   req_idx_s;

  logic [31:0]             ram [0:DEPTH-1];

  // Decode the incoming request: any access flag, word index and legality.
  always_comb begin
    req_s     = mem_ren | mem_wen;
    req_idx_s = mem_addr[ADDR_WIDTH+1:2];
    illegal_s = (mem_ren & mem_wen)
              | (mem_addr[1:0] != 2'b00)
              | ((mem_addr >> (ADDR_WIDTH + 2)) != 32'd0);
  end

  // Pipeline hold: raised in the accepting IDLE cycle and throughout BUSY.
  always_comb begin
    if (state_q == S_BUSY) begin
      mem_stall = 1'b1;
    end else if (state_q == S_IDLE) begin
      mem_stall = req_s;
    end else begin
      mem_stall = 1'b0;
    end
  end

  // Next-state, request latching and response data for the access FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    ill_d   = ill_q;
    din_d   = din_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_s) begin
          addr_d  = req_idx_s;
          wdata_d = mem_dout;
          wr_d    = mem_wen;
          ill_d   = illegal_s;
          if (illegal_s) begin
            state_d = S_RESP;
          end else if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_BUSY;
            cnt_d   = CNT_W'(WAIT_CYCLES - 1);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Response flags and read data are loaded on the edge that enters RESP.
    // addr_d is the fresh index from IDLE or the latched one from BUSY.
    if ((state_d == S_RESP) && (state_q != S_RESP)) begin
      ack_d = 1'b1;
      err_d = ill_d;
      if (!ill_d && !wr_d) begin
        din_d = ram[addr_d];
      end else begin
        din_d = din_q;
      end
    end else begin
      ack_d = 1'b0;
      err_d = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      addr_q  <= {ADDR_WIDTH{1'b0}};
      wdata_q <= 32'd0;
      wr_q    <= 1'b0;
      ill_q   <= 1'b0;
      din_q   <= 32'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      ill_q   <= ill_d;
      din_q   <= din_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // Write commit on the edge leaving RESP; a reset in RESP cancels it.
  always_ff @(posedge clk) begin
    if (!rst && (state_q == S_RESP) && wr_q && !ill_q) begin
      ram[addr_q] <= wdata_q;
    end
  end

  assign mem_din = din_q;
  assign mem_ack = ack_q;
  assign mem_err = err_q;

endmodule
